// File: rtl/rf_pkg.sv
// Shared types and sizes for the register-file write arbiter.
// Covers the write record, the pending-register vector and a one-hot decode.
package rf_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } rf_wr_t;

    typedef logic [NUM_REGS-1:0] pend_t;

    function automatic pend_t reg_onehot(input logic [ADDR_W-1:0] idx);
        pend_t v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bus bundle for the RF write arbiter: two valid/ready write requesters,
// the registered RF write port and the pending-register vector.
interface rf_write_arbiter_if;
    import rf_pkg::*;

    logic              req0_valid;
    logic              req0_ready;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;

    logic              req1_valid;
    logic              req1_ready;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;

    logic              rf_write;
    logic [ADDR_W-1:0] rf_writereg;
    logic [DATA_W-1:0] rf_data;
    pend_t             pending;

    modport master (
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready,
        input  rf_write, rf_writereg, rf_data, pending
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready,
        output rf_write, rf_writereg, rf_data, pending
    );

endinterface

// File: rtl/rf_wr_slot.sv
// One-entry holding slot for a writeback requester; frees itself when drained.
// Optional RF_R0_DISCARD_EN: writes to register 0 handshake but are dropped.
module rf_wr_slot
    import rf_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              drain,
    output logic              full,
    output rf_wr_t            entry
);

    logic accept;
    logic drop;
    logic load;

`ifdef RF_R0_DISCARD_EN
    assign drop = (in_addr == '0);
`else
    assign drop = 1'b0;
`endif

    // A slot being drained this cycle can take a new write in the same cycle.
    assign in_ready = !full || drain;
    assign accept   = in_valid && in_ready;
    assign load     = accept && !drop;

    always_ff @(posedge clk) begin
        if (reset) begin
            full  <= 1'b0;
            entry <= '0;
        end else if (load) begin
            full  <= 1'b1;
            entry <= '{addr: in_addr, data: in_data};
        end else if (drain) begin
            full  <= 1'b0;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin sharing of the RF write port between ALU and load writeback.
// Optional RF_R0_DISCARD_EN: register 0 is never written nor marked pending.
module rf_write_arbiter
    import rf_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    rf_write_arbiter_if.slave bus
);

    logic              full0;
    logic              full1;
    rf_wr_t            entry0;
    rf_wr_t            entry1;
    logic              grant0;
    logic              grant1;
    logic              same_addr;
    logic              last_grant;
    rf_wr_t            win;

    logic              rf_write_q;
    logic [ADDR_W-1:0] rf_writereg_q;
    logic [DATA_W-1:0] rf_data_q;
    pend_t             pend;

    rf_wr_slot u_slot0 (
        .clk      (clk),
        .reset    (reset),
        .in_valid (bus.req0_valid),
        .in_addr  (bus.req0_addr),
        .in_data  (bus.req0_data),
        .in_ready (bus.req0_ready),
        .drain    (grant0),
        .full     (full0),
        .entry    (entry0)
    );

    rf_wr_slot u_slot1 (
        .clk      (clk),
        .reset    (reset),
        .in_valid (bus.req1_valid),
        .in_addr  (bus.req1_addr),
        .in_data  (bus.req1_data),
        .in_ready (bus.req1_ready),
        .drain    (grant1),
        .full     (full1),
        .entry    (entry1)
    );

    // Same-address conflicts always favour slot 0 so the load value lands last.
    always_comb begin
        same_addr = (entry0.addr == entry1.addr);
        grant0    = full0 && (!full1 || same_addr || last_grant);
        grant1    = full1 && !grant0;
        win       = grant1 ? entry1 : entry0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_write_q    <= 1'b0;
            rf_writereg_q <= '0;
            rf_data_q     <= '0;
            last_grant    <= 1'b1;
        end else begin
            rf_write_q <= grant0 | grant1;
            if (grant0 | grant1) begin
                rf_writereg_q <= win.addr;
                rf_data_q     <= win.data;
                last_grant    <= grant1;
            end
        end
    end

    always_comb begin
        pend = '0;
        if (full0)
            pend = pend | reg_onehot(entry0.addr);
        if (full1)
            pend = pend | reg_onehot(entry1.addr);
        if (rf_write_q)
            pend = pend | reg_onehot(rf_writereg_q);
`ifdef RF_R0_DISCARD_EN
        pend[0] = 1'b0;
`endif
    end

    assign bus.rf_write    = rf_write_q;
    assign bus.rf_writereg = rf_writereg_q;
    assign bus.rf_data     = rf_data_q;
    assign bus.pending     = pend;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter (RF_R0_DISCARD_EN aware).
module tb_rf_write_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   i0;
    int   i1;
    logic hs0;
    logic hs1;
    logic [4:0] exp_addr [8] = '{5'd1, 5'd17, 5'd2, 5'd18, 5'd3, 5'd19, 5'd4, 5'd20};

    rf_write_arbiter_if bus ();

    rf_write_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                                 input logic v1, input logic [4:0] a1, input logic [31:0] d1);
        bus.req0_valid = v0;
        bus.req0_addr  = a0;
        bus.req0_data  = d0;
        bus.req1_valid = v1;
        bus.req1_addr  = a1;
        bus.req1_data  = d1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        checkOutput("rst_rf_write", 32'(bus.rf_write), 32'd0);
        checkOutput("rst_writereg", 32'(bus.rf_writereg), 32'd0);
        checkOutput("rst_data", bus.rf_data, 32'd0);
        checkOutput("rst_pending", bus.pending, 32'd0);
        checkOutput("rst_ready0", 32'(bus.req0_ready), 32'd1);
        checkOutput("rst_ready1", 32'(bus.req1_ready), 32'd1);

        $display("[TB] single write");
        tick();
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        checkOutput("single_ready0", 32'(bus.req0_ready), 32'd1);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        checkOutput("single_slot_wr", 32'(bus.rf_write), 32'd0);
        checkOutput("single_slot_pend", bus.pending, 32'h0000_0020);
        @(negedge clk);
        checkOutput("single_wr", 32'(bus.rf_write), 32'd1);
        checkOutput("single_reg", 32'(bus.rf_writereg), 32'd5);
        checkOutput("single_data", bus.rf_data, 32'hDEADBEEF);
        checkOutput("single_out_pend", bus.pending, 32'h0000_0020);
        @(negedge clk);
        checkOutput("single_done_wr", 32'(bus.rf_write), 32'd0);
        checkOutput("single_done_pend", bus.pending, 32'd0);
        checkOutput("single_hold_reg", 32'(bus.rf_writereg), 32'd5);
        checkOutput("single_hold_data", bus.rf_data, 32'hDEADBEEF);

        // Pointer now favours requester 1, so only the same-address rule puts 0x11 first.
        $display("[TB] same-address conflict");
        tick();
        applyStimulus(1'b1, 5'd9, 32'h11, 1'b1, 5'd9, 32'h22);
        @(negedge clk);
        checkOutput("same_ready0", 32'(bus.req0_ready), 32'd1);
        checkOutput("same_ready1", 32'(bus.req1_ready), 32'd1);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        checkOutput("same_q_wr", 32'(bus.rf_write), 32'd0);
        checkOutput("same_q_pend", bus.pending, 32'h0000_0200);
        @(negedge clk);
        checkOutput("same_1_wr", 32'(bus.rf_write), 32'd1);
        checkOutput("same_1_reg", 32'(bus.rf_writereg), 32'd9);
        checkOutput("same_1_data", bus.rf_data, 32'h11);
        checkOutput("same_1_pend", bus.pending, 32'h0000_0200);
        @(negedge clk);
        checkOutput("same_2_wr", 32'(bus.rf_write), 32'd1);
        checkOutput("same_2_reg", 32'(bus.rf_writereg), 32'd9);
        checkOutput("same_2_data", bus.rf_data, 32'h22);
        checkOutput("same_2_pend", bus.pending, 32'h0000_0200);
        @(negedge clk);
        checkOutput("same_done_wr", 32'(bus.rf_write), 32'd0);
        checkOutput("same_done_pend", bus.pending, 32'd0);

        $display("[TB] contention");
        tick();
        i0 = 0;
        i1 = 0;
        for (int c = 0; c < 11; c++) begin
            applyStimulus(i0 < 4, 5'(1 + i0), 32'hA000_0001 + 32'(i0),
                          i1 < 4, 5'(17 + i1), 32'hB000_0011 + 32'(i1));
            @(negedge clk);
            if (c >= 1 && c <= 7) begin
                checkOutput($sformatf("cont_ready0_c%0d", c), 32'(bus.req0_ready), 32'(c % 2));
                checkOutput($sformatf("cont_ready1_c%0d", c), 32'(bus.req1_ready), 32'(1 - c % 2));
            end
            if (c == 1)
                checkOutput("cont_pend_c1", bus.pending, 32'h0002_0002);
            if (c >= 2 && c <= 9) begin
                checkOutput($sformatf("cont_wr_c%0d", c), 32'(bus.rf_write), 32'd1);
                checkOutput($sformatf("cont_reg_c%0d", c), 32'(bus.rf_writereg), 32'(exp_addr[c-2]));
                checkOutput($sformatf("cont_data_c%0d", c), bus.rf_data,
                            ((exp_addr[c-2] < 5'd16) ? 32'hA000_0000 : 32'hB000_0000) | 32'(exp_addr[c-2]));
            end
            if (c == 10)
                checkOutput("cont_idle", 32'(bus.rf_write), 32'd0);
            hs0 = bus.req0_valid && bus.req0_ready;
            hs1 = bus.req1_valid && bus.req1_ready;
            tick();
            if (hs0) i0++;
            if (hs1) i1++;
        end
        checkOutput("cont_count0", 32'(i0), 32'd4);
        checkOutput("cont_count1", 32'(i1), 32'd4);

        $display("[TB] back-to-back on requester 1");
        i1 = 0;
        for (int c = 0; c < 11; c++) begin
            applyStimulus(1'b0, 5'd0, 32'd0, i1 < 8, 5'(10 + i1), 32'hC0 + 32'(i1));
            @(negedge clk);
            if (c <= 7)
                checkOutput($sformatf("b2b_ready1_c%0d", c), 32'(bus.req1_ready), 32'd1);
            if (c == 2)
                checkOutput("b2b_pend_c2", bus.pending, 32'h0000_0C00);
            if (c >= 2 && c <= 9) begin
                checkOutput($sformatf("b2b_wr_c%0d", c), 32'(bus.rf_write), 32'd1);
                checkOutput($sformatf("b2b_reg_c%0d", c), 32'(bus.rf_writereg), 32'(10 + c - 2));
                checkOutput($sformatf("b2b_data_c%0d", c), bus.rf_data, 32'hC0 + 32'(c - 2));
            end
            if (c == 10)
                checkOutput("b2b_idle", 32'(bus.rf_write), 32'd0);
            hs1 = bus.req1_valid && bus.req1_ready;
            tick();
            if (hs1) i1++;
        end

        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
        @(negedge clk);
        tick();
        applyStimulus(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        checkOutput("rstmid_pend_a", bus.pending, 32'h0000_0018);
        tick();
        reset = 1'b1;
        applyStimulus(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        checkOutput("rstmid_out_valid", 32'(bus.rf_write), 32'd1);
        checkOutput("rstmid_pend_b", bus.pending, 32'h0000_0058);
        tick();
        reset = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        checkOutput("rstmid_wr", 32'(bus.rf_write), 32'd0);
        checkOutput("rstmid_pend", bus.pending, 32'd0);
        checkOutput("rstmid_ready0", 32'(bus.req0_ready), 32'd1);
        checkOutput("rstmid_ready1", 32'(bus.req1_ready), 32'd1);
        checkOutput("rstmid_reg", 32'(bus.rf_writereg), 32'd0);
        checkOutput("rstmid_data", bus.rf_data, 32'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput($sformatf("rstmid_stale_wr_%0d", c), 32'(bus.rf_write), 32'd0);
            checkOutput($sformatf("rstmid_stale_pend_%0d", c), bus.pending, 32'd0);
        end

        $display("[TB] register 0 write");
        tick();
        applyStimulus(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        checkOutput("r0_ready0", 32'(bus.req0_ready), 32'd1);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
`ifdef RF_R0_DISCARD_EN
        checkOutput("r0_pend_q", bus.pending, 32'd0);
        @(negedge clk);
        checkOutput("r0_wr", 32'(bus.rf_write), 32'd0);
        checkOutput("r0_pend_out", bus.pending, 32'd0);
`else
        checkOutput("r0_pend_q", bus.pending, 32'h0000_0001);
        @(negedge clk);
        checkOutput("r0_wr", 32'(bus.rf_write), 32'd1);
        checkOutput("r0_reg", 32'(bus.rf_writereg), 32'd0);
        checkOutput("r0_data", bus.rf_data, 32'h55);
        checkOutput("r0_pend_out", bus.pending, 32'h0000_0001);
`endif
        @(negedge clk);
        checkOutput("r0_done_wr", 32'(bus.rf_write), 32'd0);
        checkOutput("r0_done_pend", bus.pending, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
